// File: rtl/sram_like_slave.sv
// -----------------------------------------------------------------------------
// sram_like_slave
//   Responder side of an sram-like bus backed by an internal word memory.
//   Only one transaction is outstanding at a time. A handshake (req && addr_ok)
//   latches the request. data_ok pulses LATENCY cycles later. Reads return the
//   full indexed word on rdata. Writes commit their byte lanes on the edge that
//   ends the response cycle.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words in the memory
//   LATENCY    : cycles from handshake to data_ok, legal range 1..15
//
// Ports
//   clk     in   sole clock, rising edge
//   rstn    in   asynchronous active-low reset
//   req     in   initiator request valid
//   wr      in   1 = write, 0 = read
//   size    in   0 = byte, 1 = half, 2/3 = word
//   addr    in   byte address; addr[DEPTH_LOG2+1:2] selects the word
//   wdata   in   write data, already lane-aligned
//   addr_ok out  request accepted this cycle when req is also high
//   data_ok out  one-cycle completion pulse
//   rdata   out  read word, valid while data_ok is high, held otherwise
//
// Build option
//   SRAM_LIKE_SLAVE_RAND_STALL_EN : when defined, an 8-bit LFSR randomly
//   withholds addr_ok to exercise initiator back-pressure. It never delays
//   data_ok.
// -----------------------------------------------------------------------------
module sram_like_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The counter covers the WAIT cycles after the first one. A count of 0
  // therefore means the next cycle is RESP.
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY >= 2 ? LATENCY - 2 : 0);

  logic [1:0]              state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    lat_wr;
  logic [1:0]              lat_size;
  logic [DEPTH_LOG2+1:0]   lat_addr;
  logic [31:0]             lat_wdata;

  logic                    stall;
  logic                    hs;
  logic                    commit;
  logic                    load_rdata;
  logic [3:0]              wr_be;
  logic [DEPTH_LOG2-1:0]   addr_idx, lat_idx, rd_idx;
  logic [31:0]             rd_raw, rd_fwd;

  logic [31:0]             mem [WORDS];

  // Address bits above the memory index alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  // ---------------------------------------------------------------------------
  // Optional random back-pressure
  // ---------------------------------------------------------------------------
`ifdef SRAM_LIKE_SLAVE_RAND_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci form of x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3, shifting left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and completion
  // ---------------------------------------------------------------------------
  assign addr_ok = ((state == ST_IDLE) || (state == ST_RESP)) && !stall;
  assign hs      = req && addr_ok;
  assign data_ok = (state == ST_RESP);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a value unassigned and infers a latch.
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (hs) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_d = ST_RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (hs) begin
        lat_wr    <= wr;
        lat_size  <= size;
        lat_addr  <= addr[DEPTH_LOG2+1:0];
        lat_wdata <= wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory datapath
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    byte_en = 4'b0001 << lo;
      2'd1:    byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    for (int b = 0; b < 4; b++) begin
      merge_bytes[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
  endfunction

  assign addr_idx = addr[DEPTH_LOG2+1:2];
  assign lat_idx  = lat_addr[DEPTH_LOG2+1:2];
  assign wr_be    = byte_en(lat_size, lat_addr[1:0]);
  assign commit   = (state == ST_RESP) && lat_wr;

  // A read entering RESP from WAIT uses its latched address. With LATENCY=1 it
  // enters directly from the handshake, so it uses the live address.
  assign rd_idx = (state == ST_WAIT) ? lat_idx : addr_idx;
  assign rd_raw = mem[rd_idx];

  // A LATENCY=1 read accepted in a write's RESP cycle loads rdata on the same
  // edge that commits the write. Forward the merged word so the read sees it.
  assign rd_fwd = (commit && (lat_idx == rd_idx)) ? merge_bytes(rd_raw, lat_wdata, wr_be)
                                                  : rd_raw;

  assign load_rdata = (state_d == ST_RESP) && ((state == ST_WAIT) ? !lat_wr : !wr);

  // NOTE: the memory array has no reset. Contents survive rstn, and a reset
  // port here would block RAM inference.
  always_ff @(posedge clk) begin
    if (commit) mem[lat_idx] <= merge_bytes(mem[lat_idx], lat_wdata, wr_be);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           rdata <= 32'd0;
    else if (load_rdata) rdata <= rd_fwd;
  end

endmodule

// File: tb/tb_sram_like_slave.sv
`timescale 1ns/1ps
module tb_sram_like_slave;

  localparam int N    = 3;
  localparam int I_L2 = 0;   // LATENCY=2
  localparam int I_L1 = 1;   // LATENCY=1
  localparam int I_L5 = 2;   // LATENCY=5

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req_v     [N];
  logic        wr_v      [N];
  logic [1:0]  size_v    [N];
  logic [31:0] addr_v    [N];
  logic [31:0] wdata_v   [N];
  logic [31:0] rdata_v   [N];
  logic        addr_ok_v [N];
  logic        data_ok_v [N];

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sram_like_slave #(
      .DEPTH_LOG2(10),
      .LATENCY   (g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .req    (req_v[g]),
      .wr     (wr_v[g]),
      .size   (size_v[g]),
      .addr   (addr_v[g]),
      .wdata  (wdata_v[g]),
      .addr_ok(addr_ok_v[g]),
      .data_ok(data_ok_v[g]),
      .rdata  (rdata_v[g])
    );
  end

  // Expected back-pressure: the documented LFSR sequence starting from 8'hA5.
`ifdef SRAM_LIKE_SLAVE_RAND_STALL_EN
  logic [7:0] lfsr_m;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
  wire stall_m = lfsr_m[0];
`else
  wire stall_m = 1'b0;
`endif

  function automatic int lat_of(input int i);
    return (i == I_L2) ? 2 : ((i == I_L1) ? 1 : 5);
  endfunction

  // Reference byte-lane update, written lane by lane from the access rules.
  function automatic logic [31:0] apply_write(input logic [31:0] old_word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] res;
    res = old_word;
    for (int ln = 0; ln < 4; ln++) begin
      bit sel;
      case (sz)
        2'd0:    sel = (ln == int'(a[1:0]));
        2'd1:    sel = ((ln / 2) == int'(a[1]));
        default: sel = 1'b1;
      endcase
      if (sel) res[ln*8 +: 8] = wd[ln*8 +: 8];
    end
    return res;
  endfunction

  // One transaction: hold req until accepted, then wait for data_ok.
  // lat counts cycles from the handshake cycle to the data_ok cycle (-1 = timeout).
  task automatic txn(input int i, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    req_v[i] = 1'b1; wr_v[i] = w; size_v[i] = sz; addr_v[i] = a; wdata_v[i] = wd;
    n = 0;
    while (addr_ok_v[i] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    lat = -1;
    rd  = 'x;
    if (n < 64) begin
      @(negedge clk);
      req_v[i] = 1'b0;
      lat = 1;
      while (data_ok_v[i] !== 1'b1 && lat < 32) begin @(negedge clk); lat++; end
      if (data_ok_v[i] !== 1'b1) lat = -1;
      rd = rdata_v[i];
    end else begin
      req_v[i] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (data_ok_v[i] !== 1'b0) $display("FAIL rst_data_ok[%0d] got %b want 0", i, data_ok_v[i]); else n_pass++;
      n_checks++; if (rdata_v[i] !== 32'd0) $display("FAIL rst_rdata[%0d] got %h want 0", i, rdata_v[i]); else n_pass++;
      n_checks++; if (addr_ok_v[i] !== !stall_m) $display("FAIL rst_addr_ok[%0d] got %b want %b", i, addr_ok_v[i], !stall_m); else n_pass++;
    end
    rstn = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (addr_ok_v[i] !== !stall_m) $display("FAIL post_rst_addr_ok[%0d] got %b want %b", i, addr_ok_v[i], !stall_m); else n_pass++;
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd; int lat;
    txn(I_L2, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat);
    n_checks++; if (lat !== 2) $display("FAIL basic_wr_lat got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'd0) $display("FAIL basic_wr_rdata_held got %h want 0", rd); else n_pass++;
    txn(I_L2, 1'b0, 2'd2, 32'h10, 32'h0, rd, lat);
    n_checks++; if (lat !== 2) $display("FAIL basic_rd_lat got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; int lat;
    txn(I_L2, 1'b1, 2'd2, 32'h20, 32'h11223344, rd, lat);
    txn(I_L2, 1'b1, 2'd0, 32'h22, 32'h00AA0000, rd, lat);
    txn(I_L2, 1'b0, 2'd2, 32'h20, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h11AA3344) $display("FAIL byte_lane got %h want 11aa3344", rd); else n_pass++;
    // Half write at an odd address: addr[0] ignored, upper half selected.
    txn(I_L2, 1'b1, 2'd1, 32'h23, 32'h77660000, rd, lat);
    txn(I_L2, 1'b0, 2'd1, 32'h21, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h77663344) $display("FAIL half_lane got %h want 77663344", rd); else n_pass++;
    // Word write with nonzero addr[1:0] and size 3.
    txn(I_L2, 1'b1, 2'd3, 32'h2B, 32'hCAFEF00D, rd, lat);
    txn(I_L2, 1'b0, 2'd0, 32'h28, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL word_unaligned got %h want cafef00d", rd); else n_pass++;
  endtask

  task automatic test_back_to_back;
`ifdef SRAM_LIKE_SLAVE_RAND_STALL_EN
    logic [31:0] rd; int lat;
    txn(I_L1, 1'b1, 2'd2, 32'h4, 32'h5, rd, lat);
    txn(I_L1, 1'b0, 2'd2, 32'h4, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h5) $display("FAIL b2b_rd_data got %h want 5", rd); else n_pass++;
`else
    @(negedge clk);
    req_v[I_L1] = 1'b1; wr_v[I_L1] = 1'b1; size_v[I_L1] = 2'd2; addr_v[I_L1] = 32'h4; wdata_v[I_L1] = 32'h5;
    n_checks++; if (addr_ok_v[I_L1] !== 1'b1) $display("FAIL b2b_wr_addr_ok got %b want 1", addr_ok_v[I_L1]); else n_pass++;
    @(negedge clk);
    n_checks++; if (data_ok_v[I_L1] !== 1'b1) $display("FAIL b2b_wr_data_ok got %b want 1", data_ok_v[I_L1]); else n_pass++;
    n_checks++; if (addr_ok_v[I_L1] !== 1'b1) $display("FAIL b2b_rd_addr_ok got %b want 1", addr_ok_v[I_L1]); else n_pass++;
    wr_v[I_L1] = 1'b0; wdata_v[I_L1] = 32'h0;   // req stays high
    @(negedge clk);
    req_v[I_L1] = 1'b0;
    n_checks++; if (data_ok_v[I_L1] !== 1'b1) $display("FAIL b2b_rd_data_ok got %b want 1", data_ok_v[I_L1]); else n_pass++;
    n_checks++; if (rdata_v[I_L1] !== 32'h5) $display("FAIL b2b_rd_data got %h want 5", rdata_v[I_L1]); else n_pass++;
    @(negedge clk);
    n_checks++; if (data_ok_v[I_L1] !== 1'b0) $display("FAIL b2b_idle_data_ok got %b want 0", data_ok_v[I_L1]); else n_pass++;
`endif
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int lat;
    txn(I_L2, 1'b1, 2'd2, 32'h1000, 32'h1234, rd, lat);
    txn(I_L2, 1'b0, 2'd2, 32'h0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h1234) $display("FAIL wrap got %h want 1234", rd); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat, n; bit seen;
    txn(I_L2, 1'b1, 2'd2, 32'h8, 32'h0BADF00D, rd, lat);
    txn(I_L2, 1'b0, 2'd2, 32'h8, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL rstmid_prior got %h want 0badf00d", rd); else n_pass++;
    @(negedge clk);
    req_v[I_L2] = 1'b1; wr_v[I_L2] = 1'b1; size_v[I_L2] = 2'd2; addr_v[I_L2] = 32'h8; wdata_v[I_L2] = 32'hFFFFFFFF;
    n = 0;
    while (addr_ok_v[I_L2] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    n_checks++; if (n >= 64) $display("FAIL rstmid_handshake got timeout want accept"); else n_pass++;
    @(negedge clk);
    req_v[I_L2] = 1'b0;
    n_checks++; if (data_ok_v[I_L2] !== 1'b0) $display("FAIL rstmid_wait_data_ok got %b want 0", data_ok_v[I_L2]); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (rdata_v[I_L2] !== 32'd0) $display("FAIL rstmid_rdata got %h want 0", rdata_v[I_L2]); else n_pass++;
    n_checks++; if (data_ok_v[I_L2] !== 1'b0) $display("FAIL rstmid_data_ok got %b want 0", data_ok_v[I_L2]); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (data_ok_v[I_L2] === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_stray_data_ok got 1 want 0"); else n_pass++;
    txn(I_L2, 1'b0, 2'd2, 32'h8, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL rstmid_kept got %h want 0badf00d", rd); else n_pass++;
  endtask

  // Random traffic against a transaction-level model: each accepted request
  // completes exactly LATENCY cycles later. Writes update the model word then,
  // and reads return the model word then.
  task automatic test_random(input int i, input int nreq);
    logic [31:0] mm [16];
    logic        cur_v, cw, pend, pw, exp_dok, exp_aok;
    logic [1:0]  cs, ps;
    logic [31:0] ca, cd, pa, pd, exp_rd, r;
    int          c, due, accepted, total, lat;
    lat   = lat_of(i);
    total = nreq + 16;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    exp_rd = 32'd0; pend = 1'b0; cur_v = 1'b0; accepted = 0; c = 0; due = 0;
    pw = 1'b0; ps = 2'd0; pa = 32'd0; pd = 32'd0;
    cw = 1'b0; cs = 2'd0; ca = 32'd0; cd = 32'd0;
    while ((accepted < total || pend) && c < 20000) begin
      @(negedge clk);
      c++;
      exp_dok = pend && (due == c);
      exp_aok = (!pend || exp_dok) && !stall_m;
      n_checks++; if (data_ok_v[i] !== exp_dok) $display("FAIL rnd%0d_data_ok cyc %0d got %b want %b", i, c, data_ok_v[i], exp_dok); else n_pass++;
      n_checks++; if (addr_ok_v[i] !== exp_aok) $display("FAIL rnd%0d_addr_ok cyc %0d got %b want %b", i, c, addr_ok_v[i], exp_aok); else n_pass++;
      if (exp_dok) begin
        if (pw) mm[pa[5:2]] = apply_write(mm[pa[5:2]], pd, ps, pa);
        else    exp_rd = mm[pa[5:2]];
        pend = 1'b0;
      end
      n_checks++; if (rdata_v[i] !== exp_rd) $display("FAIL rnd%0d_rdata cyc %0d got %h want %h", i, c, rdata_v[i], exp_rd); else n_pass++;
      if (!cur_v && accepted < total) begin
        r = $urandom();
        if (accepted < 16) begin
          // Fill the 16 test words first so every later read has a known value.
          cur_v = 1'b1; cw = 1'b1; cs = 2'd2; cd = $urandom();
          ca = {r[31:12], 6'd0, 4'(accepted), r[1:0]};
        end else if ($urandom_range(3) != 0) begin
          cur_v = 1'b1; cw = r[8]; cs = r[10:9]; cd = $urandom();
          ca = {r[31:12], 6'd0, r[5:2], r[1:0]};
        end
      end
      req_v[i] = cur_v;
      if (cur_v) begin
        wr_v[i] = cw; size_v[i] = cs; addr_v[i] = ca; wdata_v[i] = cd;
      end else begin
        r = $urandom();
        wr_v[i] = r[0]; size_v[i] = r[2:1]; addr_v[i] = $urandom(); wdata_v[i] = $urandom();
      end
      if (cur_v && exp_aok) begin
        pend = 1'b1; due = c + lat; pw = cw; ps = cs; pa = ca; pd = cd;
        accepted++;
        cur_v = 1'b0;
      end
    end
    req_v[i] = 1'b0;
    n_checks++; if (accepted !== total) $display("FAIL rnd%0d_accepted got %0d want %0d", i, accepted, total); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; wr_v[i] = 1'b0; size_v[i] = 2'd0; addr_v[i] = 32'd0; wdata_v[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random(I_L2, 340);
    test_random(I_L1, 340);
    test_random(I_L5, 340);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
